// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and control-word types for the pipeline control stage.
// Optional feature macro: PIPE_CTRL_FORWARDING_EN (used by pipeline_control).
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem2reg;
    logic       mem_write;
    logic       branch;
    logic       reg_dst;
    logic       alu_src_b;
    logic [2:0] alu_control;
  } ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem2reg;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem2reg;
  } wb_ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    reg_write:   1'b0,
    mem2reg:     1'b0,
    mem_write:   1'b0,
    branch:      1'b0,
    reg_dst:     1'b0,
    alu_src_b:   1'b0,
    alu_control: ALU_ADD
  };

  // MEM result is newer than WB, so it takes priority.
  function automatic logic [1:0] fwd_select(logic [4:0] src, logic rw_m, logic [4:0] wr_m,
                                            logic rw_w, logic [4:0] wr_w);
    if (rw_m && (wr_m != 5'd0) && (wr_m == src)) return FWD_MEM;
    if (rw_w && (wr_w != 5'd0) && (wr_w == src)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational main + ALU decoder: instruction in ID to a control word.
// Unrecognised opcodes or R-type functs decode to the bubble word.
module control_decoder
  import pipe_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_instr;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_instr = ^instr[25:6];

  always_comb begin
    ctrl = CTRL_BUBBLE;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  ctrl.alu_control = ALU_ADD;
          FN_SUB:  ctrl.alu_control = ALU_SUB;
          FN_AND:  ctrl.alu_control = ALU_AND;
          FN_OR:   ctrl.alu_control = ALU_OR;
          FN_SLT:  ctrl.alu_control = ALU_SLT;
          default: ctrl.alu_control = ALU_ADD;
        endcase
        if (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
        end
      end
      OP_LW: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.mem2reg   = 1'b1;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch      = 1'b1;
        ctrl.alu_control = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
      end
      default: ctrl = CTRL_BUBBLE;
    endcase
  end

endmodule

// File: rtl/pipeline_control.sv
// Control/hazard stage: decodes ID, carries control through ID/EX, EX/MEM, MEM/WB.
// Define PIPE_CTRL_FORWARDING_EN for EX forwarding; otherwise hazards are resolved by stalling.
module pipeline_control
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instrD,
  input  logic [4:0]  rsE,
  input  logic [4:0]  rtE,
  input  logic [4:0]  writeRegE,
  input  logic [4:0]  writeRegM,
  input  logic [4:0]  writeRegW,
  input  logic        zeroE,
  output logic        regWrite,
  output logic        mem2Reg,
  output logic        memWrite,
  output logic        regDst,
  output logic        aluSrcB,
  output logic [2:0]  aluControl,
  output logic [1:0]  fad,
  output logic [1:0]  fbd,
  output logic        pcSrc,
  output logic        flush,
  output logic        stall
);

  ctrl_t     ctrl_d;
  ctrl_t     id_ex_q;
  mem_ctrl_t ex_mem_q;
  wb_ctrl_t  mem_wb_q;

  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic       stall_raw;
  logic       unused_instr;

  assign rs_d         = instrD[25:21];
  assign rt_d         = instrD[20:16];
  assign unused_instr = ^instrD[15:0];

  control_decoder u_decoder (
    .instr (instrD),
    .ctrl  (ctrl_d)
  );

`ifdef PIPE_CTRL_FORWARDING_EN
  assign fad = fwd_select(rsE, ex_mem_q.reg_write, writeRegM, mem_wb_q.reg_write, writeRegW);
  assign fbd = fwd_select(rtE, ex_mem_q.reg_write, writeRegM, mem_wb_q.reg_write, writeRegW);

  // Only a load in EX cannot be forwarded in time.
  assign stall_raw = id_ex_q.mem2reg && (writeRegE != 5'd0) &&
                     ((writeRegE == rs_d) || (writeRegE == rt_d));
`else
  logic unused_fwd;
  logic hit_rs;
  logic hit_rt;

  assign fad        = FWD_RF;
  assign fbd        = FWD_RF;
  assign unused_fwd = ^{rsE, rtE, writeRegW};

  assign hit_rs = (rs_d != 5'd0) &&
                  ((id_ex_q.reg_write && (writeRegE == rs_d)) ||
                   (ex_mem_q.reg_write && (writeRegM == rs_d)));
  assign hit_rt = (rt_d != 5'd0) &&
                  ((id_ex_q.reg_write && (writeRegE == rt_d)) ||
                   (ex_mem_q.reg_write && (writeRegM == rt_d)));
  assign stall_raw = hit_rs || hit_rt;
`endif

  assign pcSrc = id_ex_q.branch & zeroE;
  assign flush = pcSrc;
  // A taken branch discards the ID instruction, so any stall it raised is moot.
  assign stall = stall_raw & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_q  <= CTRL_BUBBLE;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      id_ex_q  <= (stall || flush) ? CTRL_BUBBLE : ctrl_d;
      ex_mem_q <= '{reg_write: id_ex_q.reg_write, mem2reg: id_ex_q.mem2reg,
                    mem_write: id_ex_q.mem_write};
      mem_wb_q <= '{reg_write: ex_mem_q.reg_write, mem2reg: ex_mem_q.mem2reg};
    end
  end

  assign regWrite   = mem_wb_q.reg_write;
  assign mem2Reg    = mem_wb_q.mem2reg;
  assign memWrite   = ex_mem_q.mem_write;
  assign regDst     = id_ex_q.reg_dst;
  assign aluSrcB    = id_ex_q.alu_src_b;
  assign aluControl = id_ex_q.alu_control;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed-vector bench for pipeline_control; expectations follow the build's
// PIPE_CTRL_FORWARDING_EN setting.
module tb_pipeline_control;

  logic        clk;
  logic        rst;
  logic [31:0] instrD;
  logic [4:0]  rsE, rtE, writeRegE, writeRegM, writeRegW;
  logic        zeroE;
  logic        regWrite, mem2Reg, memWrite, regDst, aluSrcB;
  logic [2:0]  aluControl;
  logic [1:0]  fad, fbd;
  logic        pcSrc, flush, stall;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  pipeline_control dut (
    .clk        (clk),
    .rst        (rst),
    .instrD     (instrD),
    .rsE        (rsE),
    .rtE        (rtE),
    .writeRegE  (writeRegE),
    .writeRegM  (writeRegM),
    .writeRegW  (writeRegW),
    .zeroE      (zeroE),
    .regWrite   (regWrite),
    .mem2Reg    (mem2Reg),
    .memWrite   (memWrite),
    .regDst     (regDst),
    .aluSrcB    (aluSrcB),
    .aluControl (aluControl),
    .fad        (fad),
    .fbd        (fbd),
    .pcSrc      (pcSrc),
    .flush      (flush),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt);
    return {op, rs, rt, 16'h0000};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [4:0] e, input logic [4:0] m, input logic [4:0] w);
    writeRegE = e;
    writeRegM = m;
    writeRegW = w;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instrD = 32'h0;
    rsE = 5'd0;
    rtE = 5'd0;
    zeroE = 1'b0;
    set_wr(5'd0, 5'd0, 5'd0);
    tick();
    rst = 1'b0;
  endtask

  logic [31:0] add3, sub4, lw5, add6, beq12, sw21, addi, and_i, or_i, slt_i, badfn, undef;

  initial begin
    add3  = rtype(5'd1, 5'd2, 5'd3, 6'b100000);
    sub4  = rtype(5'd3, 5'd1, 5'd4, 6'b100010);
    lw5   = itype(6'b100011, 5'd0, 5'd5);
    add6  = rtype(5'd5, 5'd5, 5'd6, 6'b100000);
    beq12 = itype(6'b000100, 5'd1, 5'd2);
    sw21  = itype(6'b101011, 5'd1, 5'd2);
    addi  = itype(6'b001000, 5'd1, 5'd7);
    and_i = rtype(5'd1, 5'd2, 5'd8, 6'b100100);
    or_i  = rtype(5'd1, 5'd2, 5'd9, 6'b100101);
    slt_i = rtype(5'd1, 5'd2, 5'd10, 6'b101010);
    badfn = rtype(5'd1, 5'd2, 5'd3, 6'b100001);
    undef = {6'b111111, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000};

    // Reset values, with a live instruction already in ID
    rst = 1'b0;
    instrD = add3;
    rsE = 5'd0; rtE = 5'd0; zeroE = 1'b0;
    set_wr(5'd0, 5'd0, 5'd0);
    #1 rst = 1'b1;
    #1;
    check("rst_regWrite", 32'(regWrite), 32'd0);
    check("rst_mem2Reg", 32'(mem2Reg), 32'd0);
    check("rst_memWrite", 32'(memWrite), 32'd0);
    check("rst_regDst", 32'(regDst), 32'd0);
    check("rst_aluSrcB", 32'(aluSrcB), 32'd0);
    check("rst_aluControl", 32'(aluControl), 32'd2);
    check("rst_fwd", 32'({fad, fbd}), 32'd0);
    check("rst_hazard", 32'({pcSrc, flush, stall}), 32'd0);
    tick();
    check("rst_held_regDst", 32'(regDst), 32'd0);

    // add propagation: EX after 1 edge, WB after 3
    rst = 1'b0;
    instrD = add3;
    tick();
    check("add_ex_regDst", 32'(regDst), 32'd1);
    check("add_ex_alu", 32'(aluControl), 32'd2);
    check("add_ex_regWrite", 32'(regWrite), 32'd0);
    instrD = 32'h0;
    tick();
    check("add_mem_regDst", 32'(regDst), 32'd0);
    check("add_mem_regWrite", 32'(regWrite), 32'd0);
    tick();
    check("add_wb_regWrite", 32'(regWrite), 32'd1);
    check("add_wb_mem2Reg", 32'(mem2Reg), 32'd0);
    tick();
    check("add_gone_regWrite", 32'(regWrite), 32'd0);

    // Mid-stream async reset, then first instruction after release
    instrD = add3;
    tick();
    check("mid_pre_regDst", 32'(regDst), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_async_regDst", 32'(regDst), 32'd0);
    tick();
    rst = 1'b0;
    check("mid_after_regWrite", 32'(regWrite), 32'd0);
    tick();
    check("mid_first_regDst", 32'(regDst), 32'd1);
    tick();
    tick();
    check("mid_first_regWrite", 32'(regWrite), 32'd1);

    // add $3 -> sub $4,$3,$1
    do_reset();
    instrD = add3;
    tick();
    instrD = sub4;
    set_wr(5'd3, 5'd0, 5'd0);
    #1;
`ifdef PIPE_CTRL_FORWARDING_EN
    check("pair_stall", 32'(stall), 32'd0);
    tick();
    rsE = 5'd3; rtE = 5'd1;
    set_wr(5'd4, 5'd3, 5'd0);
    #1;
    check("pair_fad_mem", 32'(fad), 32'd2);
    check("pair_fbd_rf", 32'(fbd), 32'd0);
    check("pair_sub_alu", 32'(aluControl), 32'd6);
    // Same pair with a nop between them
    do_reset();
    instrD = add3;
    tick();
    instrD = 32'h0;
    tick();
    instrD = sub4;
    tick();
    rsE = 5'd3; rtE = 5'd1;
    set_wr(5'd4, 5'd0, 5'd3);
    #1;
    check("gap_fad_wb", 32'(fad), 32'd1);
    check("gap_fbd_rf", 32'(fbd), 32'd0);
`else
    check("pair_stall1", 32'(stall), 32'd1);
    check("pair_fwd1", 32'({fad, fbd}), 32'd0);
    tick();
    set_wr(5'd0, 5'd3, 5'd0);
    #1;
    check("pair_stall2", 32'(stall), 32'd1);
    check("pair_bubble_regDst", 32'(regDst), 32'd0);
    tick();
    set_wr(5'd0, 5'd0, 5'd3);
    #1;
    check("pair_stall3", 32'(stall), 32'd0);
    tick();
    rsE = 5'd3; rtE = 5'd1;
    set_wr(5'd4, 5'd0, 5'd0);
    #1;
    check("pair_sub_alu", 32'(aluControl), 32'd6);
    check("pair_sub_regDst", 32'(regDst), 32'd1);
    check("pair_fwd2", 32'({fad, fbd}), 32'd0);
`endif

    // lw $5 -> add $6,$5,$5
    do_reset();
    instrD = lw5;
    tick();
    check("lw_ex_aluSrcB", 32'(aluSrcB), 32'd1);
    instrD = add6;
    set_wr(5'd5, 5'd0, 5'd0);
    #1;
    check("lu_stall1", 32'(stall), 32'd1);
    tick();
    set_wr(5'd0, 5'd5, 5'd0);
    #1;
    check("lu_bubble", 32'({regDst, aluSrcB}), 32'd0);
`ifdef PIPE_CTRL_FORWARDING_EN
    check("lu_stall2", 32'(stall), 32'd0);
    tick();
    rsE = 5'd5; rtE = 5'd5;
    set_wr(5'd6, 5'd0, 5'd5);
    #1;
    check("lu_fad_wb", 32'(fad), 32'd1);
    check("lu_add_regDst", 32'(regDst), 32'd1);
`else
    check("lu_stall2", 32'(stall), 32'd1);
    tick();
    set_wr(5'd0, 5'd0, 5'd5);
    #1;
    check("lu_stall3", 32'(stall), 32'd0);
`endif
    check("lw_wb_mem2Reg", 32'(mem2Reg), 32'd1);
    check("lw_wb_regWrite", 32'(regWrite), 32'd1);

    // Taken beq, with a would-be stall in ID that flush must override
    do_reset();
    instrD = add3;
    tick();
    instrD = beq12;
    set_wr(5'd3, 5'd0, 5'd0);
    tick();
    instrD = sub4;
    set_wr(5'd0, 5'd3, 5'd0);
    zeroE = 1'b1;
    #1;
    check("beq_pcSrc", 32'(pcSrc), 32'd1);
    check("beq_flush", 32'(flush), 32'd1);
    check("beq_stall_masked", 32'(stall), 32'd0);
    check("beq_ex_alu", 32'(aluControl), 32'd6);
    tick();
    zeroE = 1'b0;
    instrD = 32'h0;
    set_wr(5'd0, 5'd0, 5'd3);
    #1;
    check("beq_bubble_alu", 32'(aluControl), 32'd2);
    check("beq_bubble_regDst", 32'(regDst), 32'd0);
    check("beq_after_pcSrc", 32'(pcSrc), 32'd0);
    // Not taken
    do_reset();
    instrD = beq12;
    tick();
    zeroE = 1'b0;
    #1;
    check("beq_nt", 32'({pcSrc, flush}), 32'd0);
    zeroE = 1'b1;
    #1;
    check("beq_nt_to_t", 32'(pcSrc), 32'd1);
    zeroE = 1'b0;

    // Decode sweep: sw, addi, and, or, slt, bad funct, undefined opcode
    do_reset();
    instrD = sw21;
    tick();
    check("sw_ex", 32'({regDst, aluSrcB, aluControl}), 32'b0_1_010);
    instrD = addi;
    tick();
    check("sw_mem_memWrite", 32'(memWrite), 32'd1);
    check("addi_ex", 32'({regDst, aluSrcB, aluControl}), 32'b0_1_010);
    instrD = and_i;
    tick();
    check("and_ex_alu", 32'(aluControl), 32'd0);
    check("addi_mem_memWrite", 32'(memWrite), 32'd0);
    check("sw_wb_regWrite", 32'(regWrite), 32'd0);
    instrD = or_i;
    tick();
    check("or_ex_alu", 32'(aluControl), 32'd1);
    check("addi_wb_regWrite", 32'(regWrite), 32'd1);
    instrD = slt_i;
    tick();
    check("slt_ex_alu", 32'(aluControl), 32'd7);
    instrD = badfn;
    tick();
    check("badfn_ex", 32'({regDst, aluSrcB, aluControl}), 32'b0_0_010);
    instrD = undef;
    tick();
    check("undef_ex", 32'({regDst, aluSrcB, aluControl}), 32'b0_0_010);
    instrD = 32'h0;
    tick();
    check("undef_mem_memWrite", 32'(memWrite), 32'd0);
    check("badfn_wb_regWrite", 32'(regWrite), 32'd0);
    tick();
    check("undef_wb_regWrite", 32'(regWrite), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
